// File: rtl/emu_ff_scan_ctrl_pkg.sv
// Shared definitions for the flip-flop scan-chain controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   scan_state_e      controller state encoding (ST_IDLE / ST_SAVE / ST_LOAD)
//   DIR_SAVE/DIR_LOAD ff_dir mux select values at the EMU_DUT boundary
//   scan_is_busy()    helper decoding "command in flight" from a state
package emu_ff_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SAVE = 2'd1,
        ST_LOAD = 2'd2
    } scan_state_e;

    // ff_dir = DIR_SAVE loops emu_ff_do back into emu_ff_di so a SAVE is a
    // full rotation; DIR_LOAD feeds ff_sdi into the chain instead.
    localparam logic DIR_SAVE = 1'b0;
    localparam logic DIR_LOAD = 1'b1;

    function automatic logic scan_is_busy(input scan_state_e st);
        return (st != ST_IDLE);
    endfunction

endpackage

// File: rtl/emu_ff_scan_ctrl_cnt.sv
// Word counter for one scan command: counts handshakes, flags the last word.
// Latency: registered count, 'last' is combinational from the count.
// Backpressure: none; advances only when the parent asserts inc.
//
// Ports:
//   emu_host_clk   in  host clock
//   emu_host_rstn  in  synchronous active-low reset (count -> 0)
//   clr            in  restart at 0 (command accept); wins over inc
//   inc            in  one word moved this cycle
//   last           out count == CHAIN_LEN-1, i.e. the next word completes the chain
module emu_scan_cnt #(
    parameter int CHAIN_LEN = 16,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic emu_host_clk,
    input  logic emu_host_rstn,
    input  logic clr,
    input  logic inc,
    output logic last
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge emu_host_clk) begin
        if (!emu_host_rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == CNT_W'(CHAIN_LEN - 1));

endmodule

// File: rtl/emu_ff_scan_ctrl.sv
// Host-side scan-chain driver: SAVE rotates the paused DUT FF chain out to a
//   stream (loopback keeps DUT state), LOAD shifts a stream into the chain.
// Latency: combinational stream<->chain path, one chain shift per handshake;
//   done/abort are registered one-cycle pulses after the final/aborting cycle.
// Backpressure: out_ready=0 (SAVE) or in_valid=0 (LOAD) holds ff_se low and
//   stalls the chain; pause=0 aborts the command without shifting.
//
// Optional feature macro: EMU_SCAN_CSUM_EN -- when defined, scan_csum is the
//   running XOR of every word moved by the current/last command (cleared on
//   command accept). When undefined the register is absent and scan_csum=0.
//
// Ports:
//   emu_host_clk/emu_host_rstn   clock, synchronous active-low reset
//   pause                        DUT is paused; required for any shift
//   cmd_valid/cmd_ready/cmd_load command handshake, cmd_load 0=SAVE 1=LOAD
//   done/abort/busy              completion pulse, abort pulse, in-flight flag
//   ff_se/ff_dir/ff_sdi/ff_sdo   EMU_DUT scan enable, di mux select, data in/out
//   out_valid/out_ready/out_data SAVE stream
//   in_valid/in_ready/in_data    LOAD stream
//   scan_csum                    XOR checksum of transferred words
module emu_ff_scan_ctrl
    import emu_ff_scan_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CHAIN_LEN  = 16
) (
    input  logic                  emu_host_clk,
    input  logic                  emu_host_rstn,
    input  logic                  pause,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_load,
    output logic                  done,
    output logic                  abort,
    output logic                  busy,
    output logic                  ff_se,
    output logic                  ff_dir,
    output logic [DATA_WIDTH-1:0] ff_sdi,
    input  logic [DATA_WIDTH-1:0] ff_sdo,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0] scan_csum
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);

    scan_state_e state_q, state_d;
    logic        done_q,  done_d;
    logic        abort_q, abort_d;

    logic is_save;
    logic is_load;
    logic run;
    logic cmd_acc;
    logic xfer;
    logic cnt_last;

    // ------------------------------------------------------------------
    // Output decode. Everything that can move the chain is qualified with
    // the reset input as well as pause: a reset edge must never coincide
    // with a shift, and the DUT clock gate must never see ff_se without
    // pause (that would double-drive the DUT flops).
    // ------------------------------------------------------------------
    always_comb begin
        is_save   = (state_q == ST_SAVE);
        is_load   = (state_q == ST_LOAD);
        run       = emu_host_rstn & pause;

        cmd_ready = emu_host_rstn & (state_q == ST_IDLE) & pause;
        cmd_acc   = cmd_valid & cmd_ready;

        out_valid = is_save & run;
        out_data  = is_save ? ff_sdo : '0;

        in_ready  = is_load & run;
        ff_sdi    = is_load ? in_data : '0;

        ff_dir    = is_load ? DIR_LOAD : DIR_SAVE;

        // One shift per stream handshake; ff_se is exactly the handshake.
        ff_se     = (is_save & run & out_ready) | (is_load & run & in_valid);
        xfer      = ff_se;
    end

    // ------------------------------------------------------------------
    // Next-state logic.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_acc) begin
                    state_d = cmd_load ? ST_LOAD : ST_SAVE;
                end
            end
            ST_SAVE, ST_LOAD: begin
                if (!pause) begin
                    // Chain is left wherever it got to; host must re-run.
                    state_d = ST_IDLE;
                    abort_d = 1'b1;
                end else if (xfer && cnt_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge emu_host_clk) begin
        if (!emu_host_rstn) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    assign done  = done_q;
    assign abort = abort_q;
    assign busy  = scan_is_busy(state_q);

    emu_scan_cnt #(
        .CHAIN_LEN (CHAIN_LEN),
        .CNT_W     (CNT_W)
    ) u_cnt (
        .emu_host_clk  (emu_host_clk),
        .emu_host_rstn (emu_host_rstn),
        .clr           (cmd_acc),
        .inc           (xfer),
        .last          (cnt_last)
    );

`ifdef EMU_SCAN_CSUM_EN
    logic [DATA_WIDTH-1:0] csum_q, csum_d;
    logic [DATA_WIDTH-1:0] xfer_word;

    always_comb begin
        xfer_word = is_load ? in_data : ff_sdo;
        csum_d    = csum_q;
        if (cmd_acc) begin
            csum_d = '0;
        end else if (xfer) begin
            csum_d = csum_q ^ xfer_word;
        end
    end

    always_ff @(posedge emu_host_clk) begin
        if (!emu_host_rstn) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign scan_csum = csum_q;
`else
    assign scan_csum = '0;
`endif

endmodule

// File: tb/tb_emu_ff_scan_ctrl.sv
// Bench for emu_ff_scan_ctrl: EMU_DUT chain (ff_dir mux, clock gate) driven by
// the controller, plus an ungated reference chain advanced from a
// transaction-level model of the command rules.
module tb_emu_ff_scan_ctrl;

    localparam int DW = 64;
    localparam int N  = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          pause;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_load;
    logic          done;
    logic          abort;
    logic          busy;
    logic          ff_se;
    logic          ff_dir;
    logic [DW-1:0] ff_sdi;
    logic [DW-1:0] ff_sdo;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [DW-1:0] scan_csum;

    always #5 clk = ~clk;

    emu_ff_scan_ctrl #(.DATA_WIDTH(DW), .CHAIN_LEN(N)) dut (
        .emu_host_clk  (clk),
        .emu_host_rstn (rstn),
        .pause         (pause),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_load      (cmd_load),
        .done          (done),
        .abort         (abort),
        .busy          (busy),
        .ff_se         (ff_se),
        .ff_dir        (ff_dir),
        .ff_sdi        (ff_sdi),
        .ff_sdo        (ff_sdo),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .scan_csum     (scan_csum)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // DUT functional next state while running (arbitrary but position dependent).
    function automatic logic [DW-1:0] fstep(input logic [DW-1:0] w, input int i);
        return {w[DW-2:0], w[DW-1]} ^ DW'(i + 1);
    endfunction

    // ---------------- EMU_DUT model: chain[0] sits at emu_ff_do -------------
    logic [DW-1:0] gchain [N];
    logic [DW-1:0] rchain [N];
    logic [DW-1:0] pre    [N];
    logic          preload_req = 1'b1;
    logic          se_s = 1'b0, dir_s = 1'b0, pause_s = 1'b1;
    logic [DW-1:0] sdi_s = '0;

    assign ff_sdo = gchain[0];

    always @(posedge clk) begin
        if (preload_req) begin
            for (int i = 0; i < N; i++) gchain[i] <= pre[i];
        end else if (se_s) begin
            for (int i = 0; i < N - 1; i++) gchain[i] <= gchain[i+1];
            gchain[N-1] <= dir_s ? sdi_s : gchain[0];
        end else if (!pause_s) begin
            for (int i = 0; i < N; i++) gchain[i] <= fstep(gchain[i], i);
        end
    end

    // ---------------- transaction model + compare process -------------------
    int            mst = 0;        // 0 idle, 1 save, 2 load
    int            mk = 0;         // words moved in current command
    logic          mdone = 1'b0, mabort = 1'b0;
    logic [DW-1:0] mcsum = '0;
    logic          chk_en = 1'b0;
    int            cyc = 0;
    logic [DW-1:0] capq[$];
    int            capcyc[$];
    int            done_cnt = 0, abort_cnt = 0;

    always @(negedge clk) begin
        logic          same;
        logic          hs;
        logic [DW-1:0] w;
        cyc++;
        if (chk_en) begin
            same = 1'b1;
            for (int i = 0; i < N; i++) if (gchain[i] !== rchain[i]) same = 1'b0;
            chk("chain_vs_ref", same, 1'b1);
            chk("busy", busy, mst != 0);
            chk("done", done, mdone);
            chk("abort", abort, mabort);
            chk("se_without_pause", ff_se & ~pause, 1'b0);
`ifdef EMU_SCAN_CSUM_EN
            chk("scan_csum", scan_csum, mcsum);
`else
            chk("scan_csum", scan_csum, '0);
`endif
            if (rstn) begin
                chk("cmd_ready", cmd_ready, mst == 0 && pause);
                chk("ff_se", ff_se, (mst == 1 && pause && out_ready) || (mst == 2 && pause && in_valid));
                chk("out_valid", out_valid, mst == 1 && pause);
                chk("in_ready", in_ready, mst == 2 && pause);
                if (mst == 1) begin
                    chk("ff_dir_save", ff_dir, 1'b0);
                    chk("out_data", out_data, rchain[0]);
                end
                if (mst == 2) begin
                    chk("ff_dir_load", ff_dir, 1'b1);
                    chk("ff_sdi", ff_sdi, in_data);
                end
            end else begin
                chk("ff_se_in_reset", ff_se, 1'b0);
            end
        end
        if (done) done_cnt++;
        if (abort) abort_cnt++;
        if (out_valid && out_ready) begin
            capq.push_back(out_data);
            capcyc.push_back(cyc);
        end
        se_s    = ff_se;
        dir_s   = ff_dir;
        sdi_s   = ff_sdi;
        pause_s = pause;

        // advance model to the state after the coming rising edge
        mdone  = 1'b0;
        mabort = 1'b0;
        if (!rstn) begin
            mst   = 0;
            mk    = 0;
            mcsum = '0;
        end else if (mst == 0) begin
            if (cmd_valid && pause) begin
                mst   = cmd_load ? 2 : 1;
                mk    = 0;
                mcsum = '0;
            end
        end else if (!pause) begin
            mst    = 0;
            mabort = 1'b1;
        end else begin
            hs = (mst == 1) ? out_ready : in_valid;
            if (hs) begin
                w = (mst == 1) ? rchain[0] : in_data;
                mcsum ^= w;
                for (int i = 0; i < N - 1; i++) rchain[i] = rchain[i+1];
                rchain[N-1] = w;
                mk++;
                if (mk == N) begin
                    mst   = 0;
                    mdone = 1'b1;
                end
            end
        end
        if (!pause) for (int i = 0; i < N; i++) rchain[i] = fstep(rchain[i], i);
        if (preload_req) for (int i = 0; i < N; i++) rchain[i] = pre[i];
    end

    // ---------------- stimulus helpers --------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload4(input logic [DW-1:0] a, b, c, d);
        pre[0] = a; pre[1] = b; pre[2] = c; pre[3] = d;
        preload_req = 1'b1;
        tick();
        preload_req = 1'b0;
    endtask

    task automatic issue(input logic ld);
        int n = 0;
        while (busy && n < 50) begin tick(); n++; end
        chk("issue_timeout", busy, 1'b0);
        cmd_valid = 1'b1;
        cmd_load  = ld;
        tick();
        cmd_valid = 1'b0;
        chk("accepted", busy, 1'b1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin tick(); n++; end
        chk("idle_timeout", busy, 1'b0);
        tick();   // let the done/abort pulse be observed
    endtask

    task automatic expect_cap(input string nm, input logic [DW-1:0] a, b, c, d);
        logic [DW-1:0] e [N];
        e[0] = a; e[1] = b; e[2] = c; e[3] = d;
        chk({nm, "_count"}, capq.size(), N);
        for (int k = 0; k < N && k < capq.size(); k++) chk({nm, "_word"}, capq[k], e[k]);
    endtask

    // ---------------- test sequence -----------------------------------------
    initial begin
        logic [DW-1:0] lw [N];
        int d0, a0;
        rstn = 1'b0; pause = 1'b1; cmd_valid = 1'b0; cmd_load = 1'b0;
        out_ready = 1'b0; in_valid = 1'b0; in_data = '0;
        pre[0] = 64'hA0; pre[1] = 64'hA1; pre[2] = 64'hA2; pre[3] = 64'hA3;
        tick(); tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_abort", abort, 1'b0);
        chk("rst_ff_se", ff_se, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_csum", scan_csum, '0);
        rstn = 1'b1; preload_req = 1'b0; chk_en = 1'b1;
        tick();
        chk("idle_cmd_ready", cmd_ready, 1'b1);

        // 1: plain SAVE
        preload4(64'hA0, 64'hA1, 64'hA2, 64'hA3);
        capq.delete(); capcyc.delete(); d0 = done_cnt;
        out_ready = 1'b1;
        issue(1'b0);
        wait_idle();
        expect_cap("t1", 64'hA0, 64'hA1, 64'hA2, 64'hA3);
        for (int k = 1; k < capcyc.size(); k++) chk("t1_consecutive", capcyc[k] - capcyc[0], k);
        chk("t1_done_once", done_cnt - d0, 1);
        chk("t1_chain_kept0", gchain[0], 64'hA0);
        chk("t1_chain_kept3", gchain[3], 64'hA3);
        pause = 1'b0;
        repeat (5) tick();
        pause = 1'b1;
        tick();

        // 2: LOAD with toggling in_valid, then SAVE back
        lw[0] = 64'h11; lw[1] = 64'h22; lw[2] = 64'h33; lw[3] = 64'h44;
        d0 = done_cnt;
        issue(1'b1);
        for (int k = 0; k < N; k++) begin
            in_valid = 1'b1; in_data = lw[k]; tick();
            if (k < N - 1) begin
                in_valid = 1'b0; in_data = {$urandom, $urandom}; tick();
            end
        end
        in_valid = 1'b0;
        wait_idle();
        chk("t2_done_once", done_cnt - d0, 1);
        chk("t2_deepest", gchain[0], 64'h11);
        capq.delete(); capcyc.delete();
        issue(1'b0);
        wait_idle();
        expect_cap("t2_save", 64'h11, 64'h22, 64'h33, 64'h44);

        // 3: SAVE with out_ready low in cycles 2..5
        preload4(64'hA0, 64'hA1, 64'hA2, 64'hA3);
        capq.delete(); capcyc.delete();
        out_ready = 1'b1;
        issue(1'b0);
        for (int c = 0; c < 30 && busy; c++) begin
            out_ready = !(c >= 2 && c <= 5);
            tick();
        end
        out_ready = 1'b1;
        wait_idle();
        expect_cap("t3", 64'hA0, 64'hA1, 64'hA2, 64'hA3);

        // 4: pause drops after two SAVE words
        preload4(64'hA0, 64'hA1, 64'hA2, 64'hA3);
        capq.delete(); capcyc.delete(); d0 = done_cnt; a0 = abort_cnt;
        issue(1'b0);
        tick(); tick();
        pause = 1'b0;
        tick();
        chk("t4_abort", abort, 1'b1);
        chk("t4_busy", busy, 1'b0);
        chk("t4_cmd_ready", cmd_ready, 1'b0);
        cmd_valid = 1'b1; tick(); tick();
        chk("t4_ignored", busy, 1'b0);
        cmd_valid = 1'b0; pause = 1'b1; tick();
        chk("t4_words", capq.size(), 2);
        chk("t4_abort_once", abort_cnt - a0, 1);
        chk("t4_no_done", done_cnt - d0, 0);

        // 5: reset in the middle of a LOAD, then a clean LOAD
        issue(1'b1);
        in_valid = 1'b1; in_data = 64'h55; tick();
        in_data = 64'h66; tick();
        rstn = 1'b0; in_data = 64'h77; tick();
        rstn = 1'b1;
        chk("t5_busy", busy, 1'b0);
        chk("t5_ff_se", ff_se, 1'b0);
        in_valid = 1'b0;
        d0 = done_cnt;
        issue(1'b1);
        for (int k = 0; k < N; k++) begin in_valid = 1'b1; in_data = 64'hC0 + DW'(k); tick(); end
        in_valid = 1'b0;
        wait_idle();
        chk("t5_done", done_cnt - d0, 1);
        chk("t5_deepest", gchain[0], 64'hC0);

        // 6: checksum of F0,0F,FF,01
        preload4(64'hF0, 64'h0F, 64'hFF, 64'h01);
        issue(1'b0);
        wait_idle();
`ifdef EMU_SCAN_CSUM_EN
        chk("t6_csum", scan_csum, 64'h01);
`else
        chk("t6_csum", scan_csum, 64'h00);
`endif

        // random traffic
        for (int r = 0; r < 3000; r++) begin
            rstn      = ($urandom_range(0, 199) != 0);
            pause     = ($urandom_range(0, 29) != 0);
            cmd_valid = $urandom_range(0, 1) == 1;
            cmd_load  = $urandom_range(0, 1) == 1;
            out_ready = $urandom_range(0, 3) != 0;
            in_valid  = $urandom_range(0, 3) != 0;
            in_data   = {$urandom, $urandom};
            tick();
        end
        rstn = 1'b1; pause = 1'b1; cmd_valid = 1'b0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
